// File: rtl/stopwatch_ctrl.sv
// BCD MM:SS stopwatch sequencer driven by divided-clock levels from the clock divider.
// Divided clocks become one-cycle sys_clk ticks; all state and outputs are registered.
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59,
  parameter int unsigned MAX_SEC = 59
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       onehz_clk,
  input  logic       twohz_clk,
  input  logic       blinker_clk,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running
);

  localparam logic [7:0] MaxMin = 8'(MAX_MIN);
  localparam logic [7:0] MaxSec = 8'(MAX_SEC);

  typedef enum logic {StRun, StPause} state_e;

  state_e     state_q, state_d;
  logic       onehz_q, twohz_q;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic       blank_min_q, blank_min_d, blank_sec_q, blank_sec_d;
  logic       tick1, tick2;
  logic [8:0] sec_next, min_next;

  // Returns {wrap, tens, ones}; wrap is set when the field was at max_val.
  function automatic logic [8:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                         input logic [7:0] max_val);
    logic [7:0] val;
    val = ({4'd0, tens} * 8'd10) + {4'd0, ones};
    if (val == max_val) begin
      bcd_inc = {1'b1, 4'd0, 4'd0};
    end else if (ones == 4'd9) begin
      bcd_inc = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      bcd_inc = {1'b0, tens, ones + 4'd1};
    end
  endfunction

  always_comb begin
    tick1       = onehz_clk & ~onehz_q;
    tick2       = twohz_clk & ~twohz_q;
    sec_next    = bcd_inc(sec_tens_q, sec_ones_q, MaxSec);
    min_next    = bcd_inc(min_tens_q, min_ones_q, MaxMin);
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    state_d     = state_q;
    if (pause_pulse) begin
      state_d = (state_q == StRun) ? StPause : StRun;
    end
    // Ticks use state_q, so a tick coinciding with pause_pulse sees the pre-toggle state.
    if (!adj) begin
      if (state_q == StRun && tick1) begin
        {sec_tens_d, sec_ones_d} = sec_next[7:0];
        if (sec_next[8]) begin
          {min_tens_d, min_ones_d} = min_next[7:0];
        end
      end
    end else if (tick2) begin
      if (sel) begin
        {sec_tens_d, sec_ones_d} = sec_next[7:0];
      end else begin
        {min_tens_d, min_ones_d} = min_next[7:0];
      end
    end
    blank_min_d = adj & ~sel & blinker_clk;
    blank_sec_d = adj & sel & blinker_clk;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      onehz_q     <= 1'b0;
      twohz_q     <= 1'b0;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      onehz_q     <= onehz_clk;
      twohz_q     <= twohz_clk;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      blank_min_q <= blank_min_d;
      blank_sec_q <= blank_sec_d;
    end
  end

  assign min_tens  = min_tens_q;
  assign min_ones  = min_ones_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
  assign running   = (state_q == StRun);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; digits are compared as a packed MMSS BCD word.
module tb_stopwatch_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       onehz_clk = 1'b0, twohz_clk = 1'b0, blinker_clk = 1'b0;
  logic       pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       blank_min, blank_sec, running;
  int         checks = 0;
  int         errors = 0;

  stopwatch_ctrl #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .onehz_clk   (onehz_clk),
    .twohz_clk   (twohz_clk),
    .blinker_clk (blinker_clk),
    .pause_pulse (pause_pulse),
    .adj         (adj),
    .sel         (sel),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .blank_min   (blank_min),
    .blank_sec   (blank_sec),
    .running     (running)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic onehz_edges(input int n);
    for (int i = 0; i < n; i++) begin
      onehz_clk = 1'b1;
      step();
      onehz_clk = 1'b0;
      step();
    end
  endtask

  task automatic twohz_edges(input int n);
    for (int i = 0; i < n; i++) begin
      twohz_clk = 1'b1;
      step();
      twohz_clk = 1'b0;
      step();
    end
  endtask

  task automatic pause();
    pause_pulse = 1'b1;
    step();
    pause_pulse = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    check("reset_digits", digits(), 16'h0000);
    check("reset_blanks", {14'd0, blank_min, blank_sec}, 16'h0000);
    check("reset_running", {15'd0, running}, 16'h0001);
    rst = 1'b0;
    step();

    // First edge: no change before the sys_clk edge, change right after it.
    onehz_clk = 1'b1;
    #1;
    check("latency_before", digits(), 16'h0000);
    step();
    check("latency_after", digits(), 16'h0001);
    onehz_clk = 1'b0;
    step();
    check("level_held_no_tick", digits(), 16'h0001);
    onehz_edges(64);
    check("count_65", digits(), 16'h0105);
    check("count_65_running", {15'd0, running}, 16'h0001);

    // Preload 59:58 through adjust mode.
    adj = 1'b1;
    sel = 1'b0;
    twohz_edges(58);
    check("adj_min_59", digits(), 16'h5905);
    sel = 1'b1;
    twohz_edges(53);
    check("adj_preload", digits(), 16'h5958);
    adj = 1'b0;
    sel = 1'b0;
    step();
    onehz_edges(1);
    check("to_5959", digits(), 16'h5959);
    onehz_edges(1);
    check("wrap_0000", digits(), 16'h0000);

    pause();
    check("paused", {15'd0, running}, 16'h0000);
    onehz_edges(10);
    check("paused_hold", digits(), 16'h0000);
    check("paused_still", {15'd0, running}, 16'h0000);
    pause();
    check("resumed", {15'd0, running}, 16'h0001);
    onehz_edges(3);
    check("resume_plus3", digits(), 16'h0003);

    // Pause coinciding with tick1 still counts that second.
    onehz_clk = 1'b1;
    pause_pulse = 1'b1;
    step();
    onehz_clk = 1'b0;
    pause_pulse = 1'b0;
    check("pause_tick_inc", digits(), 16'h0004);
    check("pause_tick_state", {15'd0, running}, 16'h0000);
    step();
    pause();
    onehz_edges(54);
    check("at_0058", digits(), 16'h0058);

    // Normal mode: simultaneous ticks, only tick1 acts.
    onehz_clk = 1'b1;
    twohz_clk = 1'b1;
    step();
    onehz_clk = 1'b0;
    twohz_clk = 1'b0;
    step();
    check("normal_both_ticks", digits(), 16'h0059);
    adj = 1'b1;
    sel = 1'b1;
    twohz_edges(1);
    check("adj_sec_back_00", digits(), 16'h0000);
    adj = 1'b0;
    onehz_edges(58);
    check("at_0058_again", digits(), 16'h0058);

    adj = 1'b1;
    sel = 1'b1;
    blinker_clk = 1'b1;
    step();
    check("blank_sec_on", {14'd0, blank_min, blank_sec}, 16'h0001);
    twohz_edges(3);
    check("adj_sec_wrap", digits(), 16'h0001);
    onehz_edges(2);
    check("adj_ignores_1hz", digits(), 16'h0001);
    blinker_clk = 1'b0;
    step();
    check("blank_sec_off", {14'd0, blank_min, blank_sec}, 16'h0000);
    sel = 1'b0;
    blinker_clk = 1'b1;
    step();
    check("blank_min_on", {14'd0, blank_min, blank_sec}, 16'h0002);
    // Adjust mode: simultaneous ticks, only tick2 acts.
    onehz_clk = 1'b1;
    twohz_clk = 1'b1;
    step();
    onehz_clk = 1'b0;
    twohz_clk = 1'b0;
    step();
    twohz_edges(1);
    check("adj_min_0201", digits(), 16'h0201);
    adj = 1'b0;
    step();
    check("normal_blanks_off", {14'd0, blank_min, blank_sec}, 16'h0000);

    // Build 12:34 in adjust, pause inside adjust, then reset between edges.
    adj = 1'b1;
    twohz_edges(10);
    sel = 1'b1;
    twohz_edges(33);
    check("at_1234", digits(), 16'h1234);
    pause();
    check("pause_in_adj", {15'd0, running}, 16'h0000);
    step();
    check("blank_before_rst", {14'd0, blank_min, blank_sec}, 16'h0001);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_digits", digits(), 16'h0000);
    check("async_rst_blanks", {14'd0, blank_min, blank_sec}, 16'h0000);
    check("async_rst_running", {15'd0, running}, 16'h0001);
    step();
    rst = 1'b0;
    adj = 1'b0;
    step();
    onehz_edges(1);
    check("post_rst_count", digits(), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
